// File: rtl/irq_controller_pkg.sv
// Shared types and constants for the interrupt controller.
// State encoding, id width and the lowest-index priority helper.
package irq_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int IRQ_ID_W  = 3;
    localparam int MAX_IRQ   = 8;
    localparam int TIMER_IDX = 0;

    // Lowest set index wins, so the timer always has top priority.
    function automatic logic [IRQ_ID_W-1:0] lowest_idx(
        input logic [MAX_IRQ-1:0] v
    );
        logic [IRQ_ID_W-1:0] idx;
        idx = '0;
        for (int i = MAX_IRQ - 1; i >= TIMER_IDX; i--) begin
            if (v[i]) idx = IRQ_ID_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Per-source input sampler plus rising-edge detector.
// IRQ_SYNC2_EN adds a two-flop synchroniser ahead of edge detect.
module irq_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic src,
    output logic rise
);

`ifdef IRQ_SYNC2_EN
    logic meta;
    logic sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= src;
            sync <= meta;
        end
    end
`else
    logic sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= 1'b0;
        else       sync <= src;
    end
`endif

    logic hist;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) hist <= 1'b0;
        else       hist <= sync;
    end

    assign rise = sync & ~hist;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge capture, masking, priority and one-at-a-time
// request/ack handshake to the CPU. Build option: IRQ_SYNC2_EN.
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int N_IRQ      = 3,
    parameter int GAP_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_IRQ-1:0]    irq_src,
    input  logic                wr_mask,
    input  logic                wr_ack,
    input  logic [7:0]          wr_data,
    output logic [N_IRQ-1:0]    irq_out,
    output logic [IRQ_ID_W-1:0] irq_id,
    output logic [MAX_IRQ-1:0]  pending,
    output logic [MAX_IRQ-1:0]  mask
);

    localparam logic [MAX_IRQ-1:0] SRC_MASK =
        MAX_IRQ'((64'd1 << N_IRQ) - 64'd1);

    logic [N_IRQ-1:0]    rise;
    logic [MAX_IRQ-1:0]  set_vec;
    logic [MAX_IRQ-1:0]  clr_vec;
    logic [MAX_IRQ-1:0]  onehot_cur;
    logic [MAX_IRQ-1:0]  live;
    logic [IRQ_ID_W-1:0] cur_id;
    logic [3:0]          gap_cnt;
    logic                ack_hit;
    state_t              state;

    for (genvar k = 0; k < N_IRQ; k++) begin : g_sync
        irq_edge_sync u_sync (
            .clk   (clk),
            .reset (reset),
            .src   (irq_src[k]),
            .rise  (rise[k])
        );
    end

    always_comb begin
        set_vec = '0;
        set_vec[N_IRQ-1:0] = rise;
    end

    assign ack_hit    = (state == REQ) && wr_ack && (wr_data[2:0] == cur_id);
    assign onehot_cur = 8'd1 << cur_id;
    assign clr_vec    = ack_hit ? onehot_cur : '0;
    assign live       = pending & mask;

    // A new edge in the ack cycle wins over the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            mask    <= '0;
        end else begin
            pending <= (pending & ~clr_vec) | set_vec;
            if (wr_mask) mask <= wr_data & SRC_MASK;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cur_id  <= '0;
            gap_cnt <= '0;
            irq_out <= '0;
            irq_id  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (live != '0) begin
                        cur_id <= lowest_idx(live);
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (ack_hit) begin
                        irq_out <= '0;
                        irq_id  <= '0;
                        gap_cnt <= 4'(GAP_CYCLES);
                        state   <= GAP;
                    end else if (!mask[cur_id]) begin
                        irq_out <= '0;
                        irq_id  <= '0;
                        state   <= IDLE;
                    end else begin
                        irq_out <= onehot_cur[N_IRQ-1:0];
                        irq_id  <= cur_id;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 4'd1;
                    if (gap_cnt == 4'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios plus random traffic,
// all checked against a cycle-level behavioural model.
module tb_irq_controller;

    localparam int N   = 3;
    localparam int GAP = 1;
`ifdef IRQ_SYNC2_EN
    localparam int L = 3;
`else
    localparam int L = 2;
`endif
    localparam logic [7:0] SRCM = 8'h07;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] irq_src = '0;
    logic         wr_mask = 1'b0;
    logic         wr_ack = 1'b0;
    logic [7:0]   wr_data = '0;
    logic [N-1:0] irq_out;
    logic [2:0]   irq_id;
    logic [7:0]   pending;
    logic [7:0]   mask;

    int checks = 0;
    int errors = 0;

    irq_controller #(.N_IRQ(N), .GAP_CYCLES(GAP)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_src (irq_src),
        .wr_mask (wr_mask),
        .wr_ack  (wr_ack),
        .wr_data (wr_data),
        .irq_out (irq_out),
        .irq_id  (irq_id),
        .pending (pending),
        .mask    (mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: raw samples history, pending/mask sets, request slot.
    logic [N-1:0] hist [3];
    logic [7:0]   m_pend, m_mask, m_live, m_rise, m_clr;
    int           m_req, m_shown, m_gap;
    logic         m_ack;

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) hist[i] = '0;
            m_pend = '0; m_mask = '0;
            m_req = -1; m_shown = 0; m_gap = 0;
        end else begin
            m_rise = 8'(hist[L-2] & ~hist[L-1]);
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = irq_src;
            m_live = m_pend & m_mask;
            m_ack = (m_req >= 0) && wr_ack && (int'(wr_data[2:0]) == m_req);
            m_clr = m_ack ? 8'(1 << m_req) : 8'h00;
            if (m_gap > 0) begin
                m_gap--;
            end else if (m_req < 0) begin
                if (m_live != 0) begin
                    m_req = lowest(m_live);
                    m_shown = 0;
                end
            end else if (m_ack) begin
                m_req = -1; m_shown = 0; m_gap = GAP;
            end else if (!m_mask[m_req]) begin
                m_req = -1; m_shown = 0;
            end else begin
                m_shown = 1;
            end
            m_pend = (m_pend & ~m_clr) | m_rise;
            if (wr_mask) m_mask = wr_data & SRCM;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            logic [N-1:0] e_out;
            e_out = m_shown ? N'(1 << m_req) : '0;
            chk("model_irq_out", 32'(irq_out), 32'(e_out));
            chk("model_pending", 32'(pending), 32'(m_pend));
            chk("model_mask", 32'(mask), 32'(m_mask));
            if (e_out != 0) chk("model_irq_id", 32'(irq_id), m_req);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wmask(input logic [7:0] d);
        wr_mask = 1'b1; wr_data = d;
        tick(1);
        wr_mask = 1'b0;
    endtask

    task automatic ack(input logic [7:0] d);
        wr_ack = 1'b1; wr_data = d;
        tick(1);
        wr_ack = 1'b0;
    endtask

    initial begin
        tick(2);
        reset = 1'b0;
        chk("rst_irq_out", 32'(irq_out), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_mask", 32'(mask), 0);
        chk("rst_irq_id", 32'(irq_id), 0);

        // Single source, latency and hold without ack.
        wmask(8'h07);
        chk("mask_7", 32'(mask), 7);
        irq_src = 3'b100;
        tick(L);
        chk("s1_pending", 32'(pending), 32'h04);
        chk("s1_not_yet", 32'(irq_out), 0);
        tick(1);
        chk("s1_not_yet2", 32'(irq_out), 0);
        tick(1);
        chk("s1_irq_out", 32'(irq_out), 32'b100);
        chk("s1_irq_id", 32'(irq_id), 2);
        tick(2);
        irq_src = '0;
        tick(5);
        chk("s1_held", 32'(irq_out), 32'b100);

        // Wrong-id ack ignored, right ack clears.
        ack(8'h01);
        chk("s2_wrong_ack", 32'(irq_out), 32'b100);
        ack(8'h02);
        chk("s2_ack_out", 32'(irq_out), 0);
        chk("s2_ack_pend", 32'(pending), 0);
        tick(GAP + 3);
        chk("s2_idle", 32'(irq_out), 0);

        // Timer beats line 1 when both arrive together.
        irq_src = 3'b011;
        tick(L);
        chk("s3_pending", 32'(pending), 32'h03);
        tick(2);
        chk("s3_first", 32'(irq_out), 32'b001);
        ack(8'h00);
        chk("s3_gap", 32'(irq_out), 0);
        chk("s3_pend", 32'(pending), 32'h02);
        tick(GAP + 1);
        chk("s3_gap_end", 32'(irq_out), 0);
        tick(1);
        chk("s3_second", 32'(irq_out), 32'b010);
        chk("s3_second_id", 32'(irq_id), 1);
        ack(8'h01);
        irq_src = '0;
        tick(GAP + 4);

        // Masked capture, then unmask.
        wmask(8'h00);
        irq_src = 3'b010;
        tick(L + 3);
        chk("s4_pending", 32'(pending), 32'h02);
        chk("s4_masked", 32'(irq_out), 0);
        wmask(8'h02);
        tick(1);
        chk("s4_one", 32'(irq_out), 0);
        tick(1);
        chk("s4_two", 32'(irq_out), 32'b010);
        ack(8'h01);
        irq_src = '0;
        tick(GAP + 4);

        // Edge and ack on bit 0 in the same cycle.
        wmask(8'h07);
        irq_src = 3'b001;
        tick(L + 2);
        chk("s5_req", 32'(irq_out), 32'b001);
        irq_src = '0;
        tick(4);
        irq_src = 3'b001;
        tick(L - 1);
        ack(8'h00);
        chk("s5_pend_kept", 32'(pending), 32'h01);
        chk("s5_gap", 32'(irq_out), 0);
        tick(GAP + 1);
        chk("s5_gap_end", 32'(irq_out), 0);
        tick(1);
        chk("s5_rereq", 32'(irq_out), 32'b001);

        // Asynchronous reset while a request is up.
        reset = 1'b1;
        irq_src = '0;
        #1;
        chk("s6_out", 32'(irq_out), 0);
        chk("s6_pend", 32'(pending), 0);
        chk("s6_mask", 32'(mask), 0);
        tick(1);
        reset = 1'b0;
        tick(6);
        chk("s6_quiet", 32'(irq_out), 0);
        chk("s6_quiet_p", 32'(pending), 0);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            tick(1);
            reset = 1'b0;
            wr_mask = 1'b0;
            wr_ack = 1'b0;
            if ($urandom_range(0, 7) == 0)
                irq_src = irq_src ^ N'(1 << $urandom_range(0, N - 1));
            if ($urandom_range(0, 5) == 0) begin
                wr_ack = 1'b1;
                if ($urandom_range(0, 1) == 1 && m_req >= 0)
                    wr_data = 8'(m_req);
                else
                    wr_data = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 24) == 0) begin
                wr_mask = 1'b1;
                if (!wr_ack) wr_data = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 599) == 0) reset = 1'b1;
        end
        reset = 1'b0;
        wr_mask = 1'b0;
        wr_ack = 1'b0;
        tick(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Source-side end of the CPU interrupt interface: captures interrupt events from external lines and the timer, and holds them as pending.
- Masks and prioritises the pending events, then presents exactly one request at a time to the CPU's interrupt inputs.
- Keeps that request asserted until the CPU acknowledges it through an output-port write.
- Sits between the board/timer interrupt sources and the CPU's interrupt vector, replacing the raw line concatenation.

Parameters:
- N_IRQ, 3, number of interrupt sources (1..8); bit 0 = timer, bits 1..N_IRQ-1 = external lines.
- GAP_CYCLES, 1, number of cycles the request output is held low after an acknowledge, before the next request is presented (1..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- irq_src  in  N_IRQ  raw interrupt sources; a rising edge is an event; may be asynchronous to clk.
- wr_mask  in  1  one-cycle strobe: load mask from wr_data.
- wr_ack  in  1  one-cycle strobe: acknowledge the interrupt whose id is on wr_data[2:0].
- wr_data  in  8  CPU output-port data.
- irq_out  out  N_IRQ  one-hot request to the CPU interrupt inputs; all zero when idle.
- irq_id  out  3  index of the active request; valid only while irq_out != 0.
- pending  out  8  pending bits, zero-extended, for CPU readback.
- mask  out  8  current enable mask, zero-extended.

Behaviour:
- Reset values: pending=0, mask=0 (all sources disabled), irq_out=0, irq_id=0, state=IDLE, edge history=0.
- Edge capture:
  - irq_src passes through synchroniser stages; see Optional Feature.
  - A rising edge on synchronised bit k sets pending[k].
  - Edges are captured even while mask[k]=0; masking only gates presentation to the CPU.
- Mask write: wr_mask=1 loads mask <= wr_data[N_IRQ-1:0]; the new mask takes effect in the next cycle.
- State machine:
  - IDLE: if (pending & mask) != 0, latch the lowest set index as cur_id and go to REQ. Lowest index has highest priority, so the timer wins.
  - REQ: irq_out = one-hot(cur_id), irq_id = cur_id.
    - On wr_ack with wr_data[2:0]==cur_id: clear pending[cur_id], load the gap counter with GAP_CYCLES, go to GAP.
    - An ack with a different id is ignored.
    - A higher-priority event arriving during REQ does not pre-empt; it waits.
    - Clearing mask[cur_id] while in REQ returns to IDLE without clearing pending.
  - GAP: irq_out=0; decrement the counter; when it reaches 0, go to IDLE.
- Latency:
  - Synchronised edge to pending set: 1 cycle.
  - pending set to irq_out asserted: 2 cycles (IDLE evaluation, then REQ register).
- Simultaneous events:
  - A new edge and an ack on the same bit in the same cycle: the set wins, pending stays 1, and the source is re-requested after GAP.
  - wr_mask and wr_ack in the same cycle are both performed.
- Events are not counted: repeated edges on an already-pending bit collapse into one request.
- Reset asserted mid-operation: immediate return to the reset values; any in-flight request is dropped.
- All outputs are registered; there is no combinational path from wr_* to irq_out.

Optional Feature:
- Macro: IRQ_SYNC2_EN.
- Defined: each irq_src bit passes through a 2-flop synchroniser, then the edge-detect flop. Total latency from the raw edge to pending set is 3 cycles.
- Undefined: irq_src is sampled by a single register feeding edge detect. Latency from the raw edge to pending set is 2 cycles. Intended only for sources already synchronous to clk, such as the timer.
- Every latency stated in the Test Plan must be offset by the difference between the two builds.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, REQ=2'd1, GAP=2'd2.
  - IRQ_ID_W=3.
  - Maximum-source constant 8.
  - Timer source index 0.
- One sub-module is natural: irq_edge_sync, a per-bit synchroniser plus rising-edge detector, instantiated N_IRQ times. Prioritiser and FSM stay in the top module.

Test Plan:
- Reset, then mask=3'b111; pulse irq_src[2] high for 5 cycles -> pending=8'h04; irq_out=3'b100 and irq_id=2 at the stated latency; stays asserted with no ack.
- In REQ with id 2, write ack with wr_data=8'h01 (wrong id) -> ignored; then ack with 8'h02 -> pending=0, irq_out=0 for exactly GAP_CYCLES cycles, then IDLE.
- Raise irq_src[1] and irq_src[0] in the same cycle, mask=3'b111 -> irq_out=3'b001 first; after ack 0 and the gap, irq_out=3'b010.
- mask=3'b000, edge on irq_src[1] -> pending=8'h02 with irq_out=0; write mask=8'h02 -> irq_out=3'b010 two cycles later.
- In REQ id 0, new edge on bit 0 in the same cycle as ack 0 -> pending[0] stays 1; irq_out=3'b001 reasserts after the gap.
- Assert reset while in REQ -> irq_out, pending and mask all 0 in the same cycle (asynchronous); no request after reset deasserts.
